// File: rtl/cnn_pkg.sv
//------------------------------------------------------------------------------
// Module      : cnn_pkg
// Description : Shared types and constants for the conv pipeline.
//               - FSM state enum for the streaming pool stage
//               - default geometry / width constants
//               - lane-slice helper (LSB position of a packed channel lane)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cnn_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NUM_CH_DEF = 6;
    localparam int IMG_W_DEF  = 28;
    localparam int IMG_H_DEF  = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pool_state_t;

    // LSB bit position of channel 'ch' in a vector packed as ch*width +: width.
    function automatic int lane_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pool_max_lane.sv
//------------------------------------------------------------------------------
// Module      : pool_max_lane
// Description : Signed two-input maximum over DATA_W bits (two's complement).
//               Ties return a_i (both operands are equal anyway).
// Ports       : a_i, b_i  - signed operands
//               max_o     - larger of the two, same width
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pool_max_lane #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] max_o
);

    assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

`default_nettype wire

// File: rtl/conv_pool_stream.sv
//------------------------------------------------------------------------------
// Module      : conv_pool_stream
// Description : Channel-parallel 2x2 / stride-2 max-pool over a raster-order
//               stream. One pixel position (all NUM_CH lanes) per input
//               handshake; one pooled beat per completed 2x2 window.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               start_i         - begin a frame (sampled in IDLE only)
//               in_valid_i/in_ready_o/in_data_i    - input stream
//               out_valid_o/out_ready_i/out_data_o - pooled stream
//               out_last_o      - marks the final pooled beat of a frame
//               busy_o          - frame in progress (RUN or DRAIN)
//               done_o          - one-cycle pulse on frame completion
// Options     : CONV_POOL_RELU_EN - clamp each pooled lane to max(x, 0)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_pool_stream
    import cnn_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_CH*DATA_W-1:0] out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int VEC_W  = NUM_CH * DATA_W;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int HALF_W = IMG_W / 2;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    pool_state_t        state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               done_q, done_d;
    logic [VEC_W-1:0]   hreg_q;
    logic [VEC_W-1:0]   lbuf_q [HALF_W];
    logic               out_valid_q;
    logic [VEC_W-1:0]   out_data_q;
    logic               out_last_q;

    logic               w_accept;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_last_px;
    logic               w_win;
    logic [IDX_W-1:0]   w_lidx;
    logic [VEC_W-1:0]   w_lbuf_rd;
    logic [VEC_W-1:0]   w_hmax;
    logic [VEC_W-1:0]   w_res;

    // A held, unconsumed beat stalls the input so no window can overwrite it.
    assign in_ready_o = (state_q == ST_RUN) && !(out_valid_q && !out_ready_i);
    assign w_accept   = in_valid_i && in_ready_o;
    assign w_col_last = (col_q == COL_W'(IMG_W - 1));
    assign w_row_last = (row_q == ROW_W'(IMG_H - 1));
    assign w_last_px  = w_accept && w_col_last && w_row_last;
    assign w_win      = w_accept && col_q[0] && row_q[0];
    assign w_lidx     = IDX_W'(col_q >> 1);
    assign w_lbuf_rd  = lbuf_q[w_lidx];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        logic signed [DATA_W-1:0] w_in;
        logic signed [DATA_W-1:0] w_hreg;
        logic signed [DATA_W-1:0] w_lb;
        logic signed [DATA_W-1:0] w_h;
        logic signed [DATA_W-1:0] w_v;

        assign w_in   = in_data_i[lane_lo(g, DATA_W) +: DATA_W];
        assign w_hreg = hreg_q[lane_lo(g, DATA_W) +: DATA_W];
        assign w_lb   = w_lbuf_rd[lane_lo(g, DATA_W) +: DATA_W];

        pool_max_lane #(.DATA_W(DATA_W)) u_hmax (
            .a_i   (w_hreg),
            .b_i   (w_in),
            .max_o (w_h)
        );

        pool_max_lane #(.DATA_W(DATA_W)) u_vmax (
            .a_i   (w_lb),
            .b_i   (w_h),
            .max_o (w_v)
        );

        assign w_hmax[lane_lo(g, DATA_W) +: DATA_W] = w_h;
`ifdef CONV_POOL_RELU_EN
        assign w_res[lane_lo(g, DATA_W) +: DATA_W] = w_v[DATA_W-1] ? '0 : w_v;
`else
        assign w_res[lane_lo(g, DATA_W) +: DATA_W] = w_v;
`endif
    end

    // State and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if (w_col_last) begin
                        col_d = '0;
                        row_d = w_row_last ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (w_last_px) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready_i && out_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: horizontal pair register, line buffer of row-pair maxima,
    // and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hreg_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (w_accept && !col_q[0]) begin
                hreg_q <= in_data_i;
            end
            if (w_win) begin
                out_valid_q <= 1'b1;
                out_data_q  <= w_res;
                out_last_q  <= w_last_px;
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HALF_W; i++) begin
                lbuf_q[i] <= '0;
            end
        end else if (w_accept && col_q[0] && !row_q[0]) begin
            lbuf_q[w_lidx] <= w_hmax;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;

endmodule

`default_nettype wire

// File: doc/conv_pool_stream.md
Name: conv_pool_stream

Overview:
- Parametrised, channel-parallel 2x2/stride-2 max-pool stage for the conv pipeline.
- Consumes raster-order conv results for NUM_CH output channels in lock-step, one pixel position per handshake, and emits pooled pixels with a valid/ready handshake.
- Replaces the per-channel fixed pooling instances with one instance for any channel count, width or image size.
- Adds backpressure, frame start/done control and a last-beat marker.

Parameters:
- DATA_W, 16: signed bits per channel sample.
- NUM_CH, 6: channels processed in parallel.
- IMG_W, 28: input columns; must be even, >= 2.
- IMG_H, 28: input rows; must be even, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- in_data  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W], signed
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  NUM_CH*DATA_W  pooled samples, same packing
- out_last  out  1  qualifies the final pooled beat of the frame
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Reset: all outputs 0; state IDLE; counters, line buffer and horizontal register cleared.
- States:
  - IDLE: start=1 -> RUN and clear col/row counters.
  - RUN: accepting pixels. Acceptance of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: waits for the final output handshake, then pulses done for 1 cycle -> IDLE.
- start outside IDLE is ignored.
- in_ready = (state==RUN) && !(out_valid && !out_ready).
- Accept = in_valid && in_ready.
- Counters: col 0..IMG_W-1 increments on accept, wraps to 0 and increments row. row 0..IMG_H-1.
- Datapath per accept, per channel, signed compare:
  - col even: hreg <= in.
  - col odd: pm = max(hreg, in).
    - row even: lbuf[col>>1] <= pm.
    - row odd: out_data <= max(lbuf[col>>1], pm); out_valid <= 1. out_last <= 1 iff this is the final pixel.
- Latency: out_valid asserts the cycle after the accept that completes a 2x2 window.
- out_valid stays high, with out_data and out_last held stable, until out_valid && out_ready. It then drops unless a new window completes in the same cycle; that new window's data replaces the old in that cycle.
- Output count per frame: (IMG_W/2)*(IMG_H/2).
- Line buffer: IMG_W/2 entries of NUM_CH*DATA_W bits. It is not cleared between frames, because even rows always overwrite an entry before odd rows read it.
- Ties in max: either operand (equal value). Comparison is two's-complement. No widening; output width equals DATA_W.
- rst mid-frame: immediate return to IDLE with all outputs 0. A partial frame is discarded.
- in_valid while in IDLE or DRAIN: not accepted, since in_ready=0.

Optional Feature:
- Macro: CONV_POOL_RELU_EN.
- Defined: each output lane is max(result, 0). Negative pooled values become 0. Applied on the output register input, so latency is unchanged.
- Undefined: raw signed max is output.

Decomposition:
- Shared package cnn_pkg:
  - state enum (IDLE, RUN, DRAIN)
  - default DATA_W/NUM_CH/IMG_W/IMG_H constants
  - lane-slice helper function
- One natural sub-module: pool_max_lane, a parametrised signed 2-input max over DATA_W, instantiated per channel for the horizontal and vertical compares.

Test Plan:
- Reset/idle: assert rst mid-cycle -> all outputs 0 asynchronously; in_valid=1 in IDLE -> in_ready=0, no output.
- Basic 4x4, NUM_CH=2, out_ready=1:
  - Stimulus: ch0 = raster values 0..15; ch1 = 15-value.
  - Response: 4 beats.
    - ch0 = 5, 7, 13, 15.
    - ch1 = 15, 13, 7, 5.
    - out_last on the 4th beat.
    - done pulses 1 cycle after the 4th handshake.
- Signed compare: window {-3, -8, -1, -20} -> -1 with the macro off. With CONV_POOL_RELU_EN defined -> 0.
- Backpressure:
  - Hold out_ready=0 after the first output -> in_ready drops, out_data held at 5 for 10 cycles.
  - Release -> remaining beats arrive intact, none dropped or duplicated.
- Bubbles: random in_valid gaps (~50%) over a 28x28 default frame -> 196 beats matching the reference max model; done exactly once.
- Reset mid-frame after 9 pixels, then start a new 4x4 frame -> output equals the clean-frame result; start pulsed during RUN has no effect.
